// File: rtl/cva6_lsu_model_param.sv
// -----------------------------------------------------------------------------
// cva6_lsu_model_param
//
// Timing model of the CVA6 load/store unit. It tracks up to LD_DEPTH
// outstanding loads and ST_DEPTH outstanding stores in two independent
// in-order queues. Memory responses retire the oldest entry of their kind.
// A load whose word address matches any pending store is held off until
// every matching store has retired (read-after-write stall).
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   instr_i          request address (byte address; bits [1:0] ignored for RAW)
//   is_load_i        1 = load, 0 = store
//   instr_valid_i    request valid
//   store_mem_resp_i retires the oldest outstanding store
//   load_mem_resp_i  retires the oldest outstanding load
//   ready_o          request can be accepted this cycle (combinational)
//   ld_count_o       outstanding loads
//   st_count_o       outstanding stores
//   raw_stall_o      a valid load is blocked by a pending-store match
//   err_o            sticky protocol error (response with nothing outstanding)
// -----------------------------------------------------------------------------
module cva6_lsu_model_param #(
    parameter int ADDR_W    = 32,
    parameter int LD_DEPTH  = 2,
    parameter int ST_DEPTH  = 4,
    parameter int RAW_CHECK = 1,
    localparam int LD_CW    = $clog2(LD_DEPTH + 1),
    localparam int ST_CW    = $clog2(ST_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] instr_i,
    input  logic              is_load_i,
    input  logic              instr_valid_i,
    input  logic              store_mem_resp_i,
    input  logic              load_mem_resp_i,
    output logic              ready_o,
    output logic [LD_CW-1:0]  ld_count_o,
    output logic [ST_CW-1:0]  st_count_o,
    output logic              raw_stall_o,
    output logic              err_o
);

    localparam int LD_PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int ST_PW = (ST_DEPTH > 1) ? $clog2(ST_DEPTH) : 1;
    localparam int TAG_W = ADDR_W - 2;

    // Store queue: word address per slot plus a valid bit that qualifies it.
    logic [TAG_W-1:0] r_st_addr [ST_DEPTH];
    logic [ST_DEPTH-1:0] r_st_valid;
    logic [ST_PW-1:0]    r_st_head;
    logic [ST_PW-1:0]    r_st_tail;
    logic [ST_CW-1:0]    r_st_count;

    // Load queue: occupancy only, load addresses are never compared.
    logic [LD_PW-1:0]    r_ld_head;
    logic [LD_PW-1:0]    r_ld_tail;
    logic [LD_CW-1:0]    r_ld_count;

    logic                r_err;

    logic [TAG_W-1:0]    w_tag;
    logic                w_raw_hit;
    logic                w_ld_room;
    logic                w_st_room;
    logic                w_ld_push;
    logic                w_st_push;
    logic                w_ld_pop;
    logic                w_st_pop;
    logic                w_resp_err;
    logic                w_unused;

    // Circular-pointer increment that wraps at DEPTH-1, so non-power-of-two
    // depths never visit the unused pointer codes.
    function automatic logic [ST_PW-1:0] st_ptr_inc(input logic [ST_PW-1:0] p);
        return (p == ST_PW'(ST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [LD_PW-1:0] ld_ptr_inc(input logic [LD_PW-1:0] p);
        return (p == LD_PW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_tag = instr_i[ADDR_W-1:2];

    // Byte offset is irrelevant to the word match; load pointers exist only
    // to keep the load queue's bookkeeping symmetrical with the store queue.
    assign w_unused = ^{instr_i[1:0], r_ld_head, r_ld_tail};

    // NOTE: combinational blocks use blocking '=' with a default assigned
    // first, so every path drives the signal and no latch is inferred.
    always_comb begin
        w_raw_hit = 1'b0;
        for (int i = 0; i < ST_DEPTH; i++) begin
            if (r_st_valid[ST_PW'(i)] && (r_st_addr[ST_PW'(i)] == w_tag)) begin
                w_raw_hit = 1'b1;
            end
        end
        if (RAW_CHECK == 0) begin
            w_raw_hit = 1'b0;
        end
    end

    // Room is judged on registered occupancy only: a response arriving this
    // cycle does not free a slot for a request in the same cycle.
    assign w_ld_room = (r_ld_count < LD_CW'(LD_DEPTH));
    assign w_st_room = (r_st_count < ST_CW'(ST_DEPTH));

    assign ready_o     = is_load_i ? (w_ld_room & ~w_raw_hit) : w_st_room;
    assign raw_stall_o = instr_valid_i & is_load_i & w_raw_hit & w_ld_room;

    assign w_ld_push = instr_valid_i &  is_load_i & ready_o;
    assign w_st_push = instr_valid_i & ~is_load_i & ready_o;

    assign w_ld_pop  = load_mem_resp_i  & (r_ld_count != '0);
    assign w_st_pop  = store_mem_resp_i & (r_st_count != '0);

    assign w_resp_err = (load_mem_resp_i  & (r_ld_count == '0))
                      | (store_mem_resp_i & (r_st_count == '0));

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_st_valid <= '0;
            r_st_head  <= '0;
            r_st_tail  <= '0;
            r_st_count <= '0;
            r_ld_head  <= '0;
            r_ld_tail  <= '0;
            r_ld_count <= '0;
            r_err      <= 1'b0;
        end else begin
            // Push needs a free slot and pop needs an occupied one, so head
            // and tail never name the same slot when both happen together.
            if (w_st_pop) begin
                r_st_valid[r_st_head] <= 1'b0;
                r_st_head             <= st_ptr_inc(r_st_head);
            end
            if (w_st_push) begin
                r_st_valid[r_st_tail] <= 1'b1;
                r_st_tail             <= st_ptr_inc(r_st_tail);
            end
            r_st_count <= r_st_count + ST_CW'(w_st_push) - ST_CW'(w_st_pop);

            if (w_ld_pop) begin
                r_ld_head <= ld_ptr_inc(r_ld_head);
            end
            if (w_ld_push) begin
                r_ld_tail <= ld_ptr_inc(r_ld_tail);
            end
            r_ld_count <= r_ld_count + LD_CW'(w_ld_push) - LD_CW'(w_ld_pop);

            if (w_resp_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: the address storage has no reset; r_st_valid qualifies every
    // slot, so stale addresses are never observed and the array maps to
    // plain flops or RAM without a reset network.
    always_ff @(posedge clk_i) begin
        if (w_st_push) begin
            r_st_addr[r_st_tail] <= w_tag;
        end
    end

    assign ld_count_o = r_ld_count;
    assign st_count_o = r_st_count;
    assign err_o      = r_err;

endmodule

// File: tb/tb_cva6_lsu_model_param.sv
// -----------------------------------------------------------------------------
// tb_cva6_lsu_model_param
//
// Scoreboard bench for cva6_lsu_model_param. Instance a uses default
// parameters (RAW_CHECK=1), instance b disables the RAW stall. The stimulus
// process drives inputs just after each rising edge and pushes the expected
// observation; the monitor compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_cva6_lsu_model_param;

    typedef struct packed {
        logic [1:0] ld;
        logic [2:0] st;
        logic       rdy;
        logic       raw;
        logic       err;
    } obs_t;

    logic clk;
    logic rst_n;

    logic [31:0] a_instr, b_instr;
    logic        a_is_load, a_valid, a_sresp, a_lresp;
    logic        b_is_load, b_valid, b_sresp, b_lresp;
    logic        a_ready, a_raw, a_err, b_ready, b_raw, b_err;
    logic [1:0]  a_ld, b_ld;
    logic [2:0]  a_st, b_st;

    obs_t  exp_q  [$];
    string name_q [$];
    int    dut_q  [$];

    int checks   = 0;
    int failures = 0;

    cva6_lsu_model_param #(
        .ADDR_W(32), .LD_DEPTH(2), .ST_DEPTH(4), .RAW_CHECK(1)
    ) u_dut_a (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .instr_i          (a_instr),
        .is_load_i        (a_is_load),
        .instr_valid_i    (a_valid),
        .store_mem_resp_i (a_sresp),
        .load_mem_resp_i  (a_lresp),
        .ready_o          (a_ready),
        .ld_count_o       (a_ld),
        .st_count_o       (a_st),
        .raw_stall_o      (a_raw),
        .err_o            (a_err)
    );

    cva6_lsu_model_param #(
        .ADDR_W(32), .LD_DEPTH(2), .ST_DEPTH(4), .RAW_CHECK(0)
    ) u_dut_b (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .instr_i          (b_instr),
        .is_load_i        (b_is_load),
        .instr_valid_i    (b_valid),
        .store_mem_resp_i (b_sresp),
        .load_mem_resp_i  (b_lresp),
        .ready_o          (b_ready),
        .ld_count_o       (b_ld),
        .st_count_o       (b_st),
        .raw_stall_o      (b_raw),
        .err_o            (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got ld=%0d st=%0d rdy=%b raw=%b err=%b, expected ld=%0d st=%0d rdy=%b raw=%b err=%b",
                     name, got.ld, got.st, got.rdy, got.raw, got.err,
                     want.ld, want.st, want.rdy, want.raw, want.err);
        end
    endtask

    // Monitor: compare every queued expectation against the selected instance.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            obs_t  want;
            obs_t  got;
            string nm;
            int    d;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            d    = dut_q.pop_front();
            if (d == 0) got = '{ld: a_ld, st: a_st, rdy: a_ready, raw: a_raw, err: a_err};
            else        got = '{ld: b_ld, st: b_st, rdy: b_ready, raw: b_raw, err: b_err};
            check(nm, got, want);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic ld, input logic [31:0] addr,
                           input logic sr, input logic lr);
        a_valid = v; a_is_load = ld; a_instr = addr; a_sresp = sr; a_lresp = lr;
    endtask

    task automatic drive_b(input logic v, input logic ld, input logic [31:0] addr,
                           input logic sr, input logic lr);
        b_valid = v; b_is_load = ld; b_instr = addr; b_sresp = sr; b_lresp = lr;
    endtask

    task automatic expect_obs(input int d, input string nm, input logic [1:0] ld,
                              input logic [2:0] st, input logic rdy,
                              input logic raw, input logic err);
        exp_q.push_back('{ld: ld, st: st, rdy: rdy, raw: raw, err: err});
        name_q.push_back(nm);
        dut_q.push_back(d);
    endtask

    // Watchdog: the directed sequence is a few dozen cycles long.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive_a(0, 0, 32'h0, 0, 0);
        drive_b(0, 0, 32'h0, 0, 0);

        // Reset state
        step; drive_a(0, 0, 32'h0, 0, 0);   expect_obs(0, "rst_store", 0, 0, 1, 0, 0);
        step; drive_a(0, 1, 32'h0, 0, 0);   expect_obs(0, "rst_load",  0, 0, 1, 0, 0);
        expect_obs(1, "rst_b", 0, 0, 1, 0, 0);

        // Three stores with no responses, then fill to four
        step; rst_n = 1'b1;
              drive_a(1, 0, 32'hcad, 0, 0); expect_obs(0, "st_0xcad", 0, 0, 1, 0, 0);
        step; drive_a(1, 0, 32'h100, 0, 0); expect_obs(0, "st_0x100", 0, 1, 1, 0, 0);
        step; drive_a(1, 0, 32'h200, 0, 0); expect_obs(0, "st_0x200", 0, 2, 1, 0, 0);
        step; drive_a(1, 0, 32'h300, 0, 0); expect_obs(0, "st_three", 0, 3, 1, 0, 0);
        step; drive_a(1, 0, 32'h400, 0, 0); expect_obs(0, "st_full",  0, 4, 0, 0, 0);

        // Load to the same word as pending store 0xcad: stalled
        step; drive_a(1, 1, 32'hcac, 0, 0); expect_obs(0, "raw_stall",     0, 4, 0, 1, 0);
        step; drive_a(1, 1, 32'hcac, 1, 0); expect_obs(0, "raw_same_cyc",  0, 4, 0, 1, 0);
        step; drive_a(1, 1, 32'hcac, 0, 0); expect_obs(0, "raw_release",   0, 3, 1, 0, 0);
        step; drive_a(0, 0, 32'h0,   0, 0); expect_obs(0, "ld_accepted",   1, 3, 1, 0, 0);

        // Two pending stores to word 0x100: stall until both retire
        step; drive_a(1, 0, 32'h101, 0, 0); expect_obs(0, "st_0x101",  1, 3, 1, 0, 0);
        step; drive_a(1, 1, 32'h103, 1, 0); expect_obs(0, "raw2_st4",  1, 4, 0, 1, 0);
        step; drive_a(1, 1, 32'h103, 1, 0); expect_obs(0, "raw2_st3",  1, 3, 0, 1, 0);
        step; drive_a(1, 1, 32'h103, 1, 0); expect_obs(0, "raw2_st2",  1, 2, 0, 1, 0);
        step; drive_a(1, 1, 32'h103, 1, 0); expect_obs(0, "raw2_st1",  1, 1, 0, 1, 0);
        step; drive_a(1, 1, 32'h103, 0, 0); expect_obs(0, "raw2_free", 1, 0, 1, 0, 0);

        // Load queue full; a response does not free a slot in the same cycle
        step; drive_a(1, 1, 32'h0, 0, 0);   expect_obs(0, "ld_full",      2, 0, 0, 0, 0);
        step; drive_a(1, 1, 32'h0, 0, 1);   expect_obs(0, "ld_no_bypass", 2, 0, 0, 0, 0);
        step; drive_a(1, 1, 32'h0, 0, 0);   expect_obs(0, "ld_refill",    1, 0, 1, 0, 0);

        // Drain loads, then a load response with nothing outstanding
        step; drive_a(0, 0, 32'h0, 0, 1);   expect_obs(0, "ld_drain2",  2, 0, 1, 0, 0);
        step; drive_a(0, 0, 32'h0, 0, 1);   expect_obs(0, "ld_drain1",  1, 0, 1, 0, 0);
        step; drive_a(0, 0, 32'h0, 0, 1);   expect_obs(0, "ld_spur",    0, 0, 1, 0, 0);
        step; drive_a(0, 0, 32'h0, 0, 0);   expect_obs(0, "err_set",    0, 0, 1, 0, 1);
        step; drive_a(0, 0, 32'h0, 1, 0);   expect_obs(0, "err_hold",   0, 0, 1, 0, 1);

        // Stores in flight, then asynchronous reset mid-burst
        step; drive_a(1, 0, 32'h10, 0, 0);  expect_obs(0, "burst_st0",  0, 0, 1, 0, 1);
        step; drive_a(1, 0, 32'h20, 0, 0);  expect_obs(0, "burst_st1",  0, 1, 1, 0, 1);
        step; drive_a(0, 0, 32'h0,  0, 0);  expect_obs(0, "burst_st2",  0, 2, 1, 0, 1);
        step; drive_a(1, 0, 32'h30, 0, 0); rst_n = 1'b0;
              expect_obs(0, "rst_mid",  0, 0, 1, 0, 0);
        step; drive_a(0, 0, 32'h0, 0, 0);   expect_obs(0, "rst_hold", 0, 0, 1, 0, 0);
        step; rst_n = 1'b1;                 expect_obs(0, "rst_out",  0, 0, 1, 0, 0);

        // Store response with nothing outstanding after reset release
        step; drive_a(0, 0, 32'h0, 1, 0);   expect_obs(0, "st_spur",    0, 0, 1, 0, 0);
        step; drive_a(0, 0, 32'h0, 0, 0);   expect_obs(0, "st_err_set", 0, 0, 1, 0, 1);

        // RAW_CHECK=0 instance: same-word load goes straight through
        step; drive_b(1, 0, 32'hcad, 0, 0); expect_obs(1, "b_st_0xcad", 0, 0, 1, 0, 0);
        step; drive_b(1, 1, 32'hcac, 0, 0); expect_obs(1, "b_ld_nostall", 0, 1, 1, 0, 0);
        step; drive_b(0, 0, 32'h0,   0, 0); expect_obs(1, "b_ld_acc",     1, 1, 1, 0, 0);

        step;
        step;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
